// File: rtl/cpu_isa_pkg.sv
// Shared ISA definitions for the multi-cycle core: opcode values,
// BRANCH control encodings and instruction field positions.
package cpu_isa_pkg;

    // Instruction field positions
    localparam int OPC_MSB = 31;
    localparam int OPC_LSB = 28;
    localparam int IMM_MSB = 15;
    localparam int IMM_LSB = 0;
    localparam int IMM_W   = IMM_MSB - IMM_LSB + 1;

    // Opcodes carried in ir[OPC_MSB:OPC_LSB]
    typedef enum logic [3:0] {
        OPC_ALU   = 4'h0,
        OPC_ALUI  = 4'h1,
        OPC_LOAD  = 4'h2,
        OPC_STORE = 4'h3,
        OPC_LDI   = 4'h4,
        OPC_MOV   = 4'h5,
        OPC_CMOV  = 4'h6,
        OPC_BR    = 4'h7,
        OPC_BMI   = 4'h8,
        OPC_BPL   = 4'h9,
        OPC_BZ    = 4'hA,
        OPC_IN    = 4'hB,
        OPC_OUT   = 4'hC,
        OPC_NOP   = 4'hE,
        OPC_HALT  = 4'hF
    } opcode_e;

    // BRANCH codes driven by the control FSM
    localparam logic [2:0] BR_NONE = 3'b000;
    localparam logic [2:0] BR_BR   = 3'b001;
    localparam logic [2:0] BR_BMI  = 3'b010;
    localparam logic [2:0] BR_BPL  = 3'b011;
    localparam logic [2:0] BR_BZ   = 3'b100;
    localparam logic [2:0] BR_CMOV = 3'b101;

    // Instruction word loaded into IR on reset and on an aborted fetch
    localparam logic [31:0] NOP_WORD = 32'hE000_0000;

    // Extract the opcode field from an instruction word
    function automatic logic [3:0] opcode_of(input logic [31:0] word);
        return word[OPC_MSB:OPC_LSB];
    endfunction

endpackage

// File: rtl/branch_resolve.sv
// Combinational branch / CMOV condition resolver. Given the BRANCH code,
// the ALU flags, the current PC and the immediate, it reports whether the
// branch is taken, the PC-relative target, the CMOV condition and whether
// the code is a reserved (illegal) one.
module branch_resolve
    import cpu_isa_pkg::*;
#(
    parameter int PC_W = 16
) (
    input  logic [2:0]       branch_i,
    input  logic             flag_n_i,
    input  logic             flag_z_i,
    input  logic [PC_W-1:0]  pc_i,
    input  logic [IMM_W-1:0] imm_i,
    output logic             taken_o,
    output logic [PC_W-1:0]  target_o,
    output logic             cmov_cond_o,
    output logic             illegal_o
);

    logic [PC_W-1:0] off_s;

    // Sign-extend (or truncate) the immediate to PC width; the target is
    // relative to the already-incremented PC.
    assign off_s       = PC_W'($signed(imm_i));
    assign target_o    = pc_i + off_s;
    assign cmov_cond_o = ~flag_z_i;

    // Decode the BRANCH code into a taken decision and an illegal flag
    always_comb begin
        taken_o   = 1'b0;
        illegal_o = 1'b0;
        case (branch_i)
            BR_NONE: taken_o = 1'b0;
            BR_BR:   taken_o = 1'b1;
            BR_BMI:  taken_o = flag_n_i;
            BR_BPL:  taken_o = ~flag_n_i & ~flag_z_i;
            BR_BZ:   taken_o = flag_z_i;
            BR_CMOV: taken_o = 1'b0;
            default: illegal_o = 1'b1;
        endcase
    end

endmodule

// File: rtl/fetch_pc_unit.sv
// Fetch / PC unit: owns PC and IR, fetches instruction words over a
// request/ready handshake with a bounded wait, and applies branch
// redirects and the CMOV condition on request from the control FSM.
module fetch_pc_unit
    import cpu_isa_pkg::*;
#(
    parameter int PC_W    = 16,
    parameter int INSTR_W = 32,
    parameter int TIMEOUT = 15
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               fetch_req,
    input  logic               br_strobe,
    input  logic [2:0]         BRANCH,
    input  logic               flag_n,
    input  logic               flag_z,
    output logic               imem_req,
    output logic [PC_W-1:0]    imem_addr,
    input  logic [INSTR_W-1:0] imem_rdata,
    input  logic               imem_ready,
    output logic [PC_W-1:0]    pc,
    output logic [INSTR_W-1:0] ir,
    output logic [3:0]         op_code,
    output logic               ir_valid,
    output logic               cmov_ok,
    output logic               fetch_err,
    output logic               seq_err
);

    localparam int CNT_W = $clog2(TIMEOUT + 1);
    localparam logic [CNT_W-1:0] TIMEOUT_C = CNT_W'(TIMEOUT);
    localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
    localparam logic [PC_W-1:0]  PC_ONE    = PC_W'(1);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_REQ  = 2'd1;
    localparam logic [1:0] ST_WAIT = 2'd2;

    logic [1:0]         state_q, state_d;
    logic [PC_W-1:0]    pc_q, pc_d;
    logic [INSTR_W-1:0] ir_q, ir_d;
    logic               req_q, req_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               irv_q, irv_d;
    logic               cmov_q, cmov_d;
    logic               ferr_q, ferr_d;
    logic               serr_q, serr_d;

    logic               br_taken_s;
    logic [PC_W-1:0]    br_target_s;
    logic               br_cmov_s;
    logic               br_illegal_s;
    logic [CNT_W-1:0]   cnt_inc_s;

    branch_resolve #(
        .PC_W (PC_W)
    ) u_branch_resolve (
        .branch_i    (BRANCH),
        .flag_n_i    (flag_n),
        .flag_z_i    (flag_z),
        .pc_i        (pc_q),
        .imm_i       (ir_q[IMM_MSB:IMM_LSB]),
        .taken_o     (br_taken_s),
        .target_o    (br_target_s),
        .cmov_cond_o (br_cmov_s),
        .illegal_o   (br_illegal_s)
    );

    // Number of WAIT cycles elapsed including the current one
    assign cnt_inc_s = cnt_q + CNT_ONE;

    // Next-state logic for the fetch FSM, PC/IR and status flags
    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        ir_d    = ir_q;
        req_d   = req_q;
        cnt_d   = cnt_q;
        irv_d   = 1'b0;
        cmov_d  = cmov_q;
        ferr_d  = ferr_q;
        serr_d  = serr_q;
        case (state_q)
            ST_IDLE: begin
                cnt_d = '0;
                // Branch is applied before a same-cycle fetch so the
                // fetch uses the redirected PC.
                if (br_strobe) begin
                    if (br_taken_s) begin
                        pc_d = br_target_s;
                    end else begin
                        pc_d = pc_q;
                    end
                    if (BRANCH == BR_CMOV) begin
                        cmov_d = br_cmov_s;
                    end else begin
                        cmov_d = cmov_q;
                    end
                    if (br_illegal_s) begin
                        serr_d = 1'b1;
                    end else begin
                        serr_d = serr_q;
                    end
                end else begin
                    pc_d = pc_q;
                end
                if (fetch_req) begin
                    state_d = ST_REQ;
                    req_d   = 1'b1;
                end else begin
                    state_d = ST_IDLE;
                    req_d   = 1'b0;
                end
            end
            ST_REQ: begin
                cnt_d = '0;
                if (fetch_req || br_strobe) begin
                    serr_d = 1'b1;
                end else begin
                    serr_d = serr_q;
                end
                if (imem_ready) begin
                    ir_d    = imem_rdata;
                    pc_d    = pc_q + PC_ONE;
                    irv_d   = 1'b1;
                    req_d   = 1'b0;
                    state_d = ST_IDLE;
                end else begin
                    state_d = ST_WAIT;
                end
            end
            ST_WAIT: begin
                if (fetch_req || br_strobe) begin
                    serr_d = 1'b1;
                end else begin
                    serr_d = serr_q;
                end
                if (imem_ready) begin
                    ir_d    = imem_rdata;
                    pc_d    = pc_q + PC_ONE;
                    irv_d   = 1'b1;
                    req_d   = 1'b0;
                    state_d = ST_IDLE;
                end else if (cnt_inc_s == TIMEOUT_C) begin
                    // Abort: present a NOP so the FSM keeps running
                    ir_d    = NOP_WORD[INSTR_W-1:0];
                    ferr_d  = 1'b1;
                    irv_d   = 1'b1;
                    req_d   = 1'b0;
                    state_d = ST_IDLE;
                end else begin
                    cnt_d = cnt_inc_s;
                end
            end
            default: begin
                state_d = ST_IDLE;
                req_d   = 1'b0;
                cnt_d   = '0;
            end
        endcase
    end

    // State and output registers with synchronous reset
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_IDLE;
            pc_q    <= '0;
            ir_q    <= NOP_WORD[INSTR_W-1:0];
            req_q   <= 1'b0;
            cnt_q   <= '0;
            irv_q   <= 1'b0;
            cmov_q  <= 1'b0;
            ferr_q  <= 1'b0;
            serr_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            ir_q    <= ir_d;
            req_q   <= req_d;
            cnt_q   <= cnt_d;
            irv_q   <= irv_d;
            cmov_q  <= cmov_d;
            ferr_q  <= ferr_d;
            serr_q  <= serr_d;
        end
    end

    assign imem_req  = req_q;
    assign imem_addr = pc_q;
    assign pc        = pc_q;
    assign ir        = ir_q;
    assign op_code   = opcode_of(ir_q);
    assign ir_valid  = irv_q;
    assign cmov_ok   = cmov_q;
    assign fetch_err = ferr_q;
    assign seq_err   = serr_q;

endmodule

// File: tb/tb_fetch_pc_unit.sv
// Scoreboard bench for fetch_pc_unit: stimulus tasks update a behavioural
// model and push expected fetch results; a monitor pops and compares on
// every ir_valid pulse.
module tb_fetch_pc_unit;

    localparam int PC_W    = 16;
    localparam int INSTR_W = 32;
    localparam int TIMEOUT = 15;
    localparam logic [31:0] NOP = 32'hE000_0000;

    logic               clk = 1'b0;
    logic               reset = 1'b1;
    logic               fetch_req = 1'b0;
    logic               br_strobe = 1'b0;
    logic [2:0]         BRANCH = 3'd0;
    logic               flag_n = 1'b0;
    logic               flag_z = 1'b0;
    logic               imem_req;
    logic [PC_W-1:0]    imem_addr;
    logic [INSTR_W-1:0] imem_rdata = '0;
    logic               imem_ready = 1'b0;
    logic [PC_W-1:0]    pc;
    logic [INSTR_W-1:0] ir;
    logic [3:0]         op_code;
    logic               ir_valid, cmov_ok, fetch_err, seq_err;

    fetch_pc_unit #(.PC_W(PC_W), .INSTR_W(INSTR_W), .TIMEOUT(TIMEOUT)) dut (
        .clk(clk), .reset(reset), .fetch_req(fetch_req), .br_strobe(br_strobe),
        .BRANCH(BRANCH), .flag_n(flag_n), .flag_z(flag_z),
        .imem_req(imem_req), .imem_addr(imem_addr), .imem_rdata(imem_rdata),
        .imem_ready(imem_ready), .pc(pc), .ir(ir), .op_code(op_code),
        .ir_valid(ir_valid), .cmov_ok(cmov_ok), .fetch_err(fetch_err),
        .seq_err(seq_err)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] ir;
        logic [15:0] pc;
        bit          ferr;
    } exp_t;

    exp_t        exp_q[$];
    exp_t        mon_e;
    int          n_cmp = 0;
    int          n_bad = 0;

    // Reference model state
    logic [15:0] m_pc;
    logic [31:0] m_ir;
    bit          m_cmov, m_ferr, m_serr;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    function automatic exp_t mk_exp();
        exp_t e;
        e.ir = m_ir; e.pc = m_pc; e.ferr = m_ferr;
        return e;
    endfunction

    // PC-relative target from the IR immediate, in plain integer arithmetic
    function automatic logic [15:0] model_target(input logic [15:0] p, input logic [31:0] w);
        logic signed [15:0] imm;
        int t;
        imm = w[15:0];
        t = int'(p) + int'(imm);
        return t[15:0];
    endfunction

    task automatic model_branch(input logic [2:0] code, input bit n, input bit z);
        bit taken;
        taken = 0;
        case (code)
            3'd1: taken = 1;
            3'd2: taken = n;
            3'd3: taken = !n && !z;
            3'd4: taken = z;
            3'd5: m_cmov = !z;
            3'd6, 3'd7: m_serr = 1;
            default: taken = 0;
        endcase
        if (taken) m_pc = model_target(m_pc, m_ir);
    endtask

    // Monitor: every ir_valid pulse must match the oldest expected fetch
    always @(negedge clk) begin
        if (ir_valid === 1'b1) begin
            if (exp_q.size() == 0) begin
                n_cmp++; n_bad++;
                $display("FAIL unexpected_ir_valid: got 1, expected 0");
            end else begin
                mon_e = exp_q.pop_front();
                chk("ir", ir, mon_e.ir);
                chk("pc_after_fetch", pc, mon_e.pc);
                chk("op_code", op_code, mon_e.ir[31:28]);
                chk("fetch_err", fetch_err, mon_e.ferr);
            end
        end
    end

    task automatic do_reset();
        reset = 1; fetch_req = 0; br_strobe = 0; imem_ready = 0;
        @(negedge clk); @(negedge clk);
        reset = 0;
        m_pc = 16'h0; m_ir = NOP; m_cmov = 0; m_ferr = 0; m_serr = 0;
        chk("rst_pc", pc, 16'h0);
        chk("rst_ir", ir, NOP);
        chk("rst_imem_req", imem_req, 1'b0);
        chk("rst_ir_valid", ir_valid, 1'b0);
        chk("rst_flags", {cmov_ok, fetch_err, seq_err}, 3'b000);
    endtask

    // One fetch; ready arrives after 'waits' wait cycles unless tmo.
    // Optionally a same-cycle branch, and a protocol violation at cycle viol_at.
    task automatic do_fetch(input int waits, input bit tmo, input bit with_br,
                            input logic [2:0] code, input bit n, input bit z,
                            input int viol_at, input bit viol_br, input logic [31:0] data);
        fetch_req = 1;
        if (with_br) begin
            br_strobe = 1; BRANCH = code; flag_n = n; flag_z = z;
            model_branch(code, n, z);
        end
        @(negedge clk);
        fetch_req = 0; br_strobe = 0;
        for (int c = 0; c <= TIMEOUT; c++) begin
            chk("imem_req_busy", imem_req, 1'b1);
            chk("imem_addr", imem_addr, m_pc);
            if (c == viol_at) begin
                if (viol_br) begin
                    br_strobe = 1; BRANCH = 3'($urandom_range(0, 7)); flag_n = 1'($urandom); flag_z = 1'($urandom);
                end else begin
                    fetch_req = 1;
                end
                m_serr = 1;
            end
            if (!tmo && c == waits) begin
                imem_ready = 1; imem_rdata = data;
                m_ir = data; m_pc = m_pc + 16'd1;
                exp_q.push_back(mk_exp());
            end else if (tmo && c == TIMEOUT) begin
                imem_rdata = $urandom;
                m_ir = NOP; m_ferr = 1;
                exp_q.push_back(mk_exp());
            end else begin
                imem_rdata = $urandom;
            end
            @(negedge clk);
            imem_ready = 0; fetch_req = 0; br_strobe = 0;
            if (!tmo && c == waits) break;
        end
        chk("imem_req_idle", imem_req, 1'b0);
        chk("seq_err", seq_err, m_serr);
    endtask

    task automatic do_branch(input logic [2:0] code, input bit n, input bit z, input bit rdy_noise);
        br_strobe = 1; BRANCH = code; flag_n = n; flag_z = z;
        imem_ready = rdy_noise; imem_rdata = $urandom;
        model_branch(code, n, z);
        @(negedge clk);
        br_strobe = 0; imem_ready = 0;
        chk("pc_branch", pc, m_pc);
        chk("cmov_ok", cmov_ok, m_cmov);
        chk("seq_err_br", seq_err, m_serr);
        chk("ir_hold", ir, m_ir);
        chk("imem_req_br", imem_req, 1'b0);
    endtask

    task automatic reset_mid_fetch();
        fetch_req = 1;
        @(negedge clk); fetch_req = 0;
        @(negedge clk); @(negedge clk);
        reset = 1;
        @(negedge clk);
        reset = 0; imem_ready = 1; imem_rdata = 32'h5555_AAAA;
        m_pc = 16'h0; m_ir = NOP; m_cmov = 0; m_ferr = 0; m_serr = 0;
        chk("imem_req_after_rst", imem_req, 1'b0);
        @(negedge clk);
        imem_ready = 0;
        chk("pc_after_rst", pc, 16'h0);
        chk("ir_after_rst", ir, NOP);
        @(negedge clk);
        chk("ir_valid_after_rst", ir_valid, 1'b0);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int op;
        do_reset();

        // Zero-wait fetch, then ir_valid must drop after one cycle
        do_fetch(0, 0, 0, 3'd0, 0, 0, -1, 0, 32'h1234_5678);
        chk("pc_first_fetch", pc, 16'h0001);
        @(negedge clk);
        chk("ir_valid_one_cycle", ir_valid, 1'b0);

        // Three wait cycles
        do_fetch(3, 0, 0, 3'd0, 0, 0, -1, 0, $urandom);
        chk("pc_wait3", pc, 16'h0002);

        // Walk to pc=0x10 with last word carrying imm=0xFFFC
        for (int i = 0; i < 13; i++) do_fetch($urandom_range(0, 4), 0, 0, 3'd0, 0, 0, -1, 0, $urandom);
        do_fetch(15, 0, 0, 3'd0, 0, 0, -1, 0, 32'h7000_FFFC);
        chk("pc_at_0x10", pc, 16'h0010);
        do_branch(3'd4, 0, 0, 0);
        chk("bz_not_taken", pc, 16'h0010);
        do_branch(3'd1, 0, 0, 0);
        chk("br_taken", pc, 16'h000C);

        // BPL flag combinations and CMOV
        do_branch(3'd3, 1, 0, 0);
        do_branch(3'd3, 0, 1, 0);
        do_branch(3'd3, 0, 0, 0);
        chk("bpl_taken", pc, 16'h0008);
        do_branch(3'd5, 0, 0, 0);
        do_branch(3'd5, 0, 1, 0);
        chk("cmov_z1", cmov_ok, 1'b0);
        chk("cmov_pc", pc, 16'h0008);

        // Timeout, then a normal fetch still works
        do_fetch(0, 1, 0, 3'd0, 0, 0, -1, 0, 32'h0);
        chk("pc_after_timeout", pc, 16'h0008);
        do_fetch(1, 0, 0, 3'd0, 0, 0, -1, 0, 32'h2000_0003);

        // Same-cycle branch and fetch
        do_fetch(0, 0, 1, 3'd1, 0, 0, -1, 0, $urandom);

        // Protocol violation during WAIT, reserved branch code
        do_fetch(5, 0, 0, 3'd0, 0, 0, 2, 0, $urandom);
        do_branch(3'd7, 0, 0, 1);

        // Reset in the middle of a fetch
        reset_mid_fetch();

        // Randomized traffic
        for (int k = 0; k < 300; k++) begin
            op = $urandom_range(0, 19);
            if (op < 8)
                do_fetch($urandom_range(0, 15), ($urandom_range(0, 9) == 0), 0, 3'd0, 0, 0, -1, 0, $urandom);
            else if (op < 15)
                do_branch(3'($urandom_range(0, 7)), 1'($urandom), 1'($urandom), 1'($urandom));
            else if (op < 17)
                do_fetch($urandom_range(0, 6), 0, 1, 3'($urandom_range(0, 7)), 1'($urandom), 1'($urandom), -1, 0, $urandom);
            else if (op < 19)
                do_fetch($urandom_range(2, 8), 0, 0, 3'd0, 0, 0, $urandom_range(0, 2), 1'($urandom), $urandom);
            else
                do_reset();
        end

        @(negedge clk);
        chk("scoreboard_empty", exp_q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/fetch_pc_unit.md
Name: fetch_pc_unit

Overview:
- Owns the Program Counter (PC) and the Instruction Register (IR).
- Sits directly upstream of the multi-cycle control FSM:
  - fetches instruction words from instruction memory over a request/ready handshake;
  - presents op_code to the control FSM;
  - resolves BR/BMI/BPL/BZ redirects and the CMOV condition from the FSM's BRANCH code and the ALU status flags.
- The control FSM pulses fetch_req (its FETCH-state loadPC) and br_strobe (its EXECUTE-state loadPC for branch/CMOV opcodes).

Parameters:
- PC_W, 16, PC width in bits; PC is a word address.
- INSTR_W, 32, instruction width.
- TIMEOUT, 15, maximum wait cycles for imem_ready before a fetch is aborted.

Ports:
- clk  in  1  system clock, all logic on rising edge
- reset  in  1  synchronous, active-high reset
- fetch_req  in  1  one-cycle pulse: fetch the instruction at PC
- br_strobe  in  1  one-cycle pulse: evaluate BRANCH this cycle
- BRANCH  in  3  000 none, 001 BR, 010 BMI, 011 BPL, 100 BZ, 101 CMOV, others reserved
- flag_n  in  1  ALU negative flag
- flag_z  in  1  ALU zero flag
- imem_req  out  1  read request to instruction memory
- imem_addr  out  PC_W  read address (equals PC)
- imem_rdata  in  INSTR_W  instruction data, valid when imem_ready=1
- imem_ready  in  1  memory completes the read this cycle
- pc  out  PC_W  current PC
- ir  out  INSTR_W  instruction register
- op_code  out  4  ir[31:28]
- ir_valid  out  1  one-cycle pulse when ir is updated
- cmov_ok  out  1  registered CMOV condition result
- fetch_err  out  1  sticky: fetch timed out
- seq_err  out  1  sticky: protocol violation

Behaviour:
- Reset values: pc=0, ir=0xE000_0000 (NOP), imem_req=0, ir_valid=0, cmov_ok=0, fetch_err=0, seq_err=0, state=IDLE, wait counter=0.
- States: IDLE, REQ, WAIT.
- IDLE:
  - fetch_req=1 -> REQ.
  - br_strobe=1 -> evaluate the branch (rules below); stay in IDLE.
  - fetch_req and br_strobe in the same cycle: the branch is applied first, then the fetch request is taken at the updated PC (next cycle's imem_addr is the new PC); state -> REQ.
- REQ:
  - imem_req=1, imem_addr=pc, counter cleared.
  - imem_ready=1 -> capture immediately (same rules as WAIT).
  - otherwise -> WAIT.
- WAIT:
  - imem_req held at 1 and imem_addr held stable.
  - counter increments each cycle.
  - On imem_ready=1: ir<=imem_rdata, pc<=pc+1 (wraps modulo 2^PC_W), ir_valid=1 for the next cycle, -> IDLE.
  - On counter==TIMEOUT with no imem_ready: ir<=NOP, pc unchanged, fetch_err<=1, ir_valid pulses, -> IDLE.
- Minimum fetch latency: 1 cycle from the fetch_req edge to the ir_valid pulse when memory is zero-wait.
- Branch evaluation (single cycle, on br_strobe in IDLE):
  - Flags are sampled in the br_strobe cycle.
  - Target = pc + sext(ir[15:0]), truncated to PC_W. Because pc has already been incremented, the offset is relative to the next sequential instruction.
  - 001: always taken. 010: taken if flag_n. 011: taken if !flag_n && !flag_z. 100: taken if flag_z.
  - Taken -> pc<=target. Not taken -> pc unchanged.
  - 101: pc unchanged; cmov_ok<=!flag_z. cmov_ok holds until the next br_strobe with 101, or reset.
  - 000 and reserved codes: no effect, except reserved codes set seq_err.
- Protocol violations:
  - fetch_req or br_strobe arriving in REQ/WAIT is ignored and sets seq_err.
  - imem_ready in IDLE is ignored.
- Reset mid-fetch: imem_req drops on the cycle after reset, any late imem_ready is ignored, and no ir_valid is produced.
- No combinational path from inputs to imem_req/imem_addr/pc/ir; op_code is a direct slice of ir.

Decomposition:
- Shared package `cpu_isa_pkg`:
  - opcode constants (ALU..HALT, NOP=4'hE);
  - BRANCH encodings 000..101;
  - OPC_MSB/OPC_LSB field positions;
  - IMM field positions.
- Sub-module `branch_resolve`:
  - combinational inputs: BRANCH, flags, pc, imm;
  - outputs: taken, target, cmov_cond, illegal;
  - reusable by a future pipelined core.

Test Plan:
1. Reset, zero-wait memory returning 0x1234_5678 -> pc=0x0001, op_code=0x1, ir_valid high exactly 1 cycle.
2. Memory with 3 wait cycles -> imem_req high 4 cycles with imem_addr stable, then ir captured and pc increments by 1.
3. pc=0x0010, ir[15:0]=0xFFFC, BRANCH=001 -> pc=0x000C. Same setup, BRANCH=100 with flag_z=0 -> pc stays 0x0010.
4. BRANCH=011 under each flag combination:
   - n=0,z=0 -> taken;
   - n=1,z=0 or n=0,z=1 -> not taken.
   - BRANCH=101 with z=1 -> cmov_ok=0, pc unchanged.
5. No imem_ready for 16 cycles -> fetch_err=1, op_code=0xE, pc unchanged. A subsequent fetch_req still works.
6. fetch_req during WAIT -> seq_err=1, fetch continues normally. Reset asserted in WAIT, then imem_ready -> no ir_valid, pc=0.
